display_stream_router: RTL

DISPLAY_STREAM_ROUTER -- requirements
Module: display_stream_router

---
 rtl/display_stream_router.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/display_stream_router.sv
// display_stream_router: parses header-tagged packets (IMAGE/BBOX/LOGO) into a
// type-tagged first-word-fall-through output FIFO. Payload beats past the
// expected length are dropped, and malformed packets raise error pulses.
// Optional statistics counters are built only when DISPLAY_ROUTER_STATS_EN
// is defined; otherwise pkt_count/err_count are tied to zero.
`timescale 1ns/1ps
module display_stream_router #(
  parameter int DATA_W       = 64,
  parameter int PIX_PER_CLK  = 2,
  parameter int FRAME_WIDTH  = 540,
  parameter int FRAME_HEIGHT = 540,
  parameter int LOGO_WIDTH   = 540,
  parameter int LOGO_HEIGHT  = 100,
  parameter int MAX_BBOX     = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int AFULL_LEVEL  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_type,
  output logic              out_last,
  output logic              err_short,
  output logic              err_type,
  output logic              err_long,
  output logic [15:0]       pkt_count,
  output logic [15:0]       err_count
);

  localparam int N_IMG  = FRAME_WIDTH * FRAME_HEIGHT / PIX_PER_CLK;
  localparam int N_BBOX = MAX_BBOX;
  localparam int N_LOGO = LOGO_WIDTH * LOGO_HEIGHT / PIX_PER_CLK;
  localparam int N_MAX  = (N_IMG > N_BBOX) ? ((N_IMG > N_LOGO) ? N_IMG : N_LOGO)
                                           : ((N_BBOX > N_LOGO) ? N_BBOX : N_LOGO);
  localparam int CNT_W  = (N_MAX > 1) ? $clog2(N_MAX) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int EW     = DATA_W + 4;

  localparam logic [CNT_W-1:0] IMG_END  = CNT_W'(N_IMG - 1);
  localparam logic [CNT_W-1:0] BBOX_END = CNT_W'(N_BBOX - 1);
  localparam logic [CNT_W-1:0] LOGO_END = CNT_W'(N_LOGO - 1);
  localparam logic [AW:0]      AFULL_C  = (AW + 1)'(AFULL_LEVEL);

  // State codes for the payload states double as the header codes and the
  // output type tag.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_IMAGE = 3'd1;
  localparam logic [2:0] S_BBOX  = 3'd2;
  localparam logic [2:0] S_LOGO  = 3'd3;
  localparam logic [2:0] S_SKIP  = 3'd4;

  logic [2:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_end;
  logic             r_long_pend, w_long_pend_nxt;
  logic             r_in_ready;
  logic             w_accept, w_push, w_pop, w_last_flag;
  logic             w_err_short, w_err_type, w_err_long;
  logic             r_err_short, r_err_type, r_err_long;

  logic [EW-1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count, w_count_nxt;
  logic [EW-1:0]    w_head;

  assign w_accept = in_valid & r_in_ready;
  assign in_ready = r_in_ready;

  // Packet parser: next state, beat counter, push decision and error causes.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_long_pend_nxt = r_long_pend;
    w_push          = 1'b0;
    w_err_short     = 1'b0;
    w_err_type      = 1'b0;
    w_err_long      = 1'b0;
    case (r_state)
      S_IMAGE: w_cnt_end = IMG_END;
      S_BBOX:  w_cnt_end = BBOX_END;
      S_LOGO:  w_cnt_end = LOGO_END;
      default: w_cnt_end = '0;
    endcase
    w_last_flag = (r_cnt == w_cnt_end) | in_last;
    if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          w_cnt_nxt       = '0;
          w_long_pend_nxt = 1'b0;
          if (in_data[2:0] == S_IMAGE || in_data[2:0] == S_BBOX || in_data[2:0] == S_LOGO) begin
            if (in_last) w_err_short = 1'b1;
            else         w_state_nxt = in_data[2:0];
          end else begin
            w_err_type = 1'b1;
            if (!in_last) w_state_nxt = S_SKIP;
          end
        end
        S_IMAGE, S_BBOX, S_LOGO: begin
          w_push = 1'b1;
          if (r_cnt == w_cnt_end) begin
            if (in_last) begin
              w_state_nxt = S_IDLE;
            end else begin
              // Payload complete but the packet keeps going: drop the rest.
              w_state_nxt     = S_SKIP;
              w_long_pend_nxt = 1'b1;
            end
          end else if (in_last) begin
            w_state_nxt = S_IDLE;
            w_err_short = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          if (in_last) begin
            w_state_nxt     = S_IDLE;
            w_err_long      = r_long_pend;
            w_long_pend_nxt = 1'b0;
          end
        end
      endcase
    end
  end

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Control registers: FSM, counter, FIFO pointers, ready and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_long_pend <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b0;
      r_err_short <= 1'b0;
      r_err_type  <= 1'b0;
      r_err_long  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_long_pend <= w_long_pend_nxt;
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_count_nxt < AFULL_C);
      r_err_short <= w_err_short;
      r_err_type  <= w_err_type;
      r_err_long  <= w_err_long;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // FIFO storage: data only, no reset needed since empty entries are masked.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_state, w_last_flag, in_data};
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid & out_ready;
  assign out_data  = out_valid ? w_head[DATA_W-1:0] : '0;
  assign out_last  = out_valid ? w_head[DATA_W] : 1'b0;
  assign out_type  = out_valid ? w_head[EW-1:EW-3] : 3'd0;
  assign err_short = r_err_short;
  assign err_type  = r_err_type;
  assign err_long  = r_err_long;

`ifdef DISPLAY_ROUTER_STATS_EN
  logic [15:0] r_pkt_count, r_err_count;

  // Saturating statistics: every accepted in_last ends a packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_count <= '0;
      r_err_count <= '0;
    end else begin
      if (w_accept && in_last && r_pkt_count != 16'hFFFF)
        r_pkt_count <= r_pkt_count + 1'b1;
      if ((r_err_short | r_err_type | r_err_long) && r_err_count != 16'hFFFF)
        r_err_count <= r_err_count + 1'b1;
    end
  end

  assign pkt_count = r_pkt_count;
  assign err_count = r_err_count;
`else
  assign pkt_count = '0;
  assign err_count = '0;
`endif

endmodule
